// File: rtl/coeff_token_dec_vlc3.sv
// coeff_token_dec_vlc3: CAVLC coeff_token decoder for 4 <= nC < 8.
// Stage 1 captures the top 10 window bits with their leading-zero count,
// stage 2 performs the table lookup and holds the result for the consumer.
module coeff_token_dec_vlc3 #(
  parameter int unsigned WIN_W = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIN_W-1:0] bits_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [4:0]       total_coeff_o,
  output logic [1:0]       trailing_ones_o,
  output logic [4:0]       code_len_o,
  output logic             err_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CNT_W-1:0] tok_cnt_o
);

  localparam int unsigned TOP_W = 10;
  localparam int unsigned LZ_W  = 4;

  logic [TOP_W-1:0] top_c;
  logic [LZ_W-1:0]  lz_c;
  logic             s1_valid;
  logic [TOP_W-1:0] s1_bits;
  logic [LZ_W-1:0]  s1_lz;
  logic             adv2_c;
  logic             in_xfer_c;
  logic             out_xfer_c;
  logic [TOP_W-1:0] norm_c;
  logic [2:0]       sfx_c;
  logic [6:0]       dec_tok_c;   // {TrailingOnes, TotalCoeff}
  logic [3:0]       dec_len_c;
  logic             dec_err_c;

  assign top_c = bits_i[WIN_W-1 -: TOP_W];

  // Window bits past the longest codeword never influence the result.
  generate
    if (WIN_W > TOP_W) begin : g_tail
      logic unused_tail;
      assign unused_tail = ^bits_i[WIN_W-TOP_W-1:0];
    end
  endgenerate

  // Leading-zero count of the top 10 bits; 10 means no 1 was found.
  always_comb begin
    lz_c = LZ_W'(TOP_W);
    for (int i = 0; i < TOP_W; i++) begin
      if (top_c[i]) lz_c = LZ_W'(TOP_W - 1 - i);
    end
  end

  // Handshake and pipeline advance.
  assign adv2_c     = s1_valid & (~out_valid_o | out_ready_i);
  assign in_ready_o = ~s1_valid | adv2_c;
  assign in_xfer_c  = in_valid_i & in_ready_o;
  assign out_xfer_c = out_valid_o & out_ready_i;

  // Left-justify so the first 1 sits at the MSB; the next three bits select the entry.
  assign norm_c = s1_bits << s1_lz;
  assign sfx_c  = norm_c[TOP_W-2 -: 3];

  // VLC3 table lookup keyed by leading-zero count and the suffix after the first 1.
  always_comb begin
    dec_err_c = 1'b0;
    dec_tok_c = '0;
    case ({s1_lz, sfx_c})
      {4'd0, 3'd7}: dec_tok_c = {2'd0, 5'd0};
      {4'd0, 3'd6}: dec_tok_c = {2'd1, 5'd1};
      {4'd0, 3'd5}: dec_tok_c = {2'd2, 5'd2};
      {4'd0, 3'd4}: dec_tok_c = {2'd3, 5'd3};
      {4'd0, 3'd3}: dec_tok_c = {2'd3, 5'd4};
      {4'd0, 3'd2}: dec_tok_c = {2'd3, 5'd5};
      {4'd0, 3'd1}: dec_tok_c = {2'd3, 5'd6};
      {4'd0, 3'd0}: dec_tok_c = {2'd3, 5'd7};
      {4'd1, 3'd7}: dec_tok_c = {2'd1, 5'd2};
      {4'd1, 3'd6}: dec_tok_c = {2'd2, 5'd3};
      {4'd1, 3'd5}: dec_tok_c = {2'd3, 5'd8};
      {4'd1, 3'd4}: dec_tok_c = {2'd1, 5'd3};
      {4'd1, 3'd3}: dec_tok_c = {2'd2, 5'd4};
      {4'd1, 3'd2}: dec_tok_c = {2'd1, 5'd4};
      {4'd1, 3'd1}: dec_tok_c = {2'd2, 5'd5};
      {4'd1, 3'd0}: dec_tok_c = {2'd1, 5'd5};
      {4'd2, 3'd7}: dec_tok_c = {2'd0, 5'd1};
      {4'd2, 3'd6}: dec_tok_c = {2'd1, 5'd6};
      {4'd2, 3'd5}: dec_tok_c = {2'd2, 5'd6};
      {4'd2, 3'd4}: dec_tok_c = {2'd3, 5'd9};
      {4'd2, 3'd3}: dec_tok_c = {2'd0, 5'd2};
      {4'd2, 3'd2}: dec_tok_c = {2'd1, 5'd7};
      {4'd2, 3'd1}: dec_tok_c = {2'd2, 5'd7};
      {4'd2, 3'd0}: dec_tok_c = {2'd0, 5'd3};
      {4'd3, 3'd7}: dec_tok_c = {2'd0, 5'd4};
      {4'd3, 3'd6}: dec_tok_c = {2'd1, 5'd8};
      {4'd3, 3'd5}: dec_tok_c = {2'd2, 5'd8};
      {4'd3, 3'd4}: dec_tok_c = {2'd3, 5'd10};
      {4'd3, 3'd3}: dec_tok_c = {2'd0, 5'd5};
      {4'd3, 3'd2}: dec_tok_c = {2'd2, 5'd9};
      {4'd3, 3'd1}: dec_tok_c = {2'd0, 5'd6};
      {4'd3, 3'd0}: dec_tok_c = {2'd0, 5'd7};
      {4'd4, 3'd7}: dec_tok_c = {2'd0, 5'd8};
      {4'd4, 3'd6}: dec_tok_c = {2'd1, 5'd9};
      {4'd4, 3'd5}: dec_tok_c = {2'd2, 5'd10};
      {4'd4, 3'd4}: dec_tok_c = {2'd3, 5'd11};
      {4'd4, 3'd3}: dec_tok_c = {2'd0, 5'd9};
      {4'd4, 3'd2}: dec_tok_c = {2'd1, 5'd10};
      {4'd4, 3'd1}: dec_tok_c = {2'd2, 5'd11};
      {4'd4, 3'd0}: dec_tok_c = {2'd3, 5'd12};
      {4'd5, 3'd7}: dec_tok_c = {2'd0, 5'd10};
      {4'd5, 3'd6}: dec_tok_c = {2'd1, 5'd11};
      {4'd5, 3'd5}: dec_tok_c = {2'd2, 5'd12};
      {4'd5, 3'd4}: dec_tok_c = {2'd3, 5'd13};
      {4'd5, 3'd3}: dec_tok_c = {2'd0, 5'd11};
      {4'd5, 3'd2}: dec_tok_c = {2'd1, 5'd12};
      {4'd5, 3'd1}: dec_tok_c = {2'd2, 5'd13};
      {4'd5, 3'd0}: dec_tok_c = {2'd0, 5'd12};
      {4'd6, 3'd7},
      {4'd6, 3'd6}: dec_tok_c = {2'd1, 5'd13};
      {4'd6, 3'd5}: dec_tok_c = {2'd0, 5'd13};
      {4'd6, 3'd4}: dec_tok_c = {2'd1, 5'd14};
      {4'd6, 3'd3}: dec_tok_c = {2'd2, 5'd14};
      {4'd6, 3'd2}: dec_tok_c = {2'd3, 5'd14};
      {4'd6, 3'd1}: dec_tok_c = {2'd0, 5'd14};
      {4'd6, 3'd0}: dec_tok_c = {2'd1, 5'd15};
      {4'd7, 3'd6}: dec_tok_c = {2'd2, 5'd15};
      {4'd7, 3'd4}: dec_tok_c = {2'd3, 5'd15};
      {4'd7, 3'd2}: dec_tok_c = {2'd0, 5'd15};
      {4'd7, 3'd0}: dec_tok_c = {2'd1, 5'd16};
      {4'd8, 3'd4}: dec_tok_c = {2'd2, 5'd16};
      {4'd8, 3'd0}: dec_tok_c = {2'd3, 5'd16};
      {4'd9, 3'd0}: dec_tok_c = {2'd0, 5'd16};
      default:      dec_err_c = 1'b1;
    endcase
  end

  // Code length follows from the prefix; only lz=6 has two lengths.
  always_comb begin
    dec_len_c = 4'd10;
    if (s1_lz <= 4'd5)                     dec_len_c = s1_lz + 4'd4;
    else if (s1_lz == 4'd6 && sfx_c[2:1] == 2'b11) dec_len_c = 4'd9;
    if (dec_err_c)                         dec_len_c = 4'd0;
  end

  // Stage 1: capture window head and its leading-zero count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_bits  <= '0;
      s1_lz    <= '0;
    end else if (in_xfer_c) begin
      s1_valid <= 1'b1;
      s1_bits  <= top_c;
      s1_lz    <= lz_c;
    end else if (adv2_c) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: register the decoded token; hold it while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_o     <= 1'b0;
      total_coeff_o   <= '0;
      trailing_ones_o <= '0;
      code_len_o      <= '0;
      err_o           <= 1'b0;
    end else if (adv2_c) begin
      out_valid_o     <= 1'b1;
      trailing_ones_o <= dec_tok_c[6:5];
      total_coeff_o   <= dec_tok_c[4:0];
      code_len_o      <= 5'(dec_len_c);
      err_o           <= dec_err_c;
    end else if (out_xfer_c) begin
      out_valid_o     <= 1'b0;
    end
  end

  // Count successfully delivered, error-free tokens.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tok_cnt_o <= '0;
    end else if (out_xfer_c && !err_o) begin
      tok_cnt_o <= tok_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_coeff_token_dec_vlc3.sv
// Bench for coeff_token_dec_vlc3: directed vectors, stall/reset sequences,
// codeword sweep and randomized traffic against a prefix-matching model.
module tb_coeff_token_dec_vlc3;

  localparam int unsigned WIN_W = 16;
  localparam int unsigned CNT_W = 16;
  localparam int N_ENT = 62;

  typedef struct {
    logic [15:0] bits;
    int          tc;
    int          t1;
    int          len;
    bit          err;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [15:0]      bits = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [4:0]       tc;
  logic [1:0]       t1;
  logic [4:0]       len;
  logic             err;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] tok_cnt;

  int   checks = 0;
  int   failures = 0;
  int   exp_tok = 0;
  vec_t exp_q[$];
  vec_t mon_e;
  int   enc_ok;
  int   e_len[N_ENT];
  int   e_code[N_ENT];
  int   e_t1[N_ENT];
  int   e_tc[N_ENT];
  int   n_ent = 0;
  vec_t vecs[5];
  vec_t sv;
  logic [15:0] rnd;
  bit   done;

  coeff_token_dec_vlc3 #(.WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bits_i(bits), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .total_coeff_o(tc), .trailing_ones_o(t1),
    .code_len_o(len), .err_o(err), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .tok_cnt_o(tok_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic int pack(input int c, input int o, input int l, input bit e);
    return (int'(e) << 20) | (l << 12) | (o << 8) | c;
  endfunction

  task automatic add(input int l, input int c, input int o, input int n);
    e_len[n_ent] = l; e_code[n_ent] = c; e_t1[n_ent] = o; e_tc[n_ent] = n;
    n_ent++;
  endtask

  // Codeword list: (length, code, TrailingOnes, TotalCoeff).
  task automatic build_table();
    add(4,'b1111,0,0); add(4,'b1110,1,1); add(4,'b1101,2,2); add(4,'b1100,3,3);
    add(4,'b1011,3,4); add(4,'b1010,3,5); add(4,'b1001,3,6); add(4,'b1000,3,7);
    add(5,'b01111,1,2); add(5,'b01110,2,3); add(5,'b01101,3,8); add(5,'b01100,1,3);
    add(5,'b01011,2,4); add(5,'b01010,1,4); add(5,'b01001,2,5); add(5,'b01000,1,5);
    add(6,'b001111,0,1); add(6,'b001110,1,6); add(6,'b001101,2,6); add(6,'b001100,3,9);
    add(6,'b001011,0,2); add(6,'b001010,1,7); add(6,'b001001,2,7); add(6,'b001000,0,3);
    add(7,'b0001111,0,4); add(7,'b0001110,1,8); add(7,'b0001101,2,8); add(7,'b0001100,3,10);
    add(7,'b0001011,0,5); add(7,'b0001010,2,9); add(7,'b0001001,0,6); add(7,'b0001000,0,7);
    add(8,'b00001111,0,8); add(8,'b00001110,1,9); add(8,'b00001101,2,10); add(8,'b00001100,3,11);
    add(8,'b00001011,0,9); add(8,'b00001010,1,10); add(8,'b00001001,2,11); add(8,'b00001000,3,12);
    add(9,'b000001111,0,10); add(9,'b000001110,1,11); add(9,'b000001101,2,12); add(9,'b000001100,3,13);
    add(9,'b000001011,0,11); add(9,'b000001010,1,12); add(9,'b000001001,2,13); add(9,'b000001000,0,12);
    add(9,'b000000111,1,13);
    add(10,'b0000001101,0,13); add(10,'b0000001100,1,14); add(10,'b0000001011,2,14);
    add(10,'b0000001010,3,14); add(10,'b0000001001,0,14); add(10,'b0000001000,1,15);
    add(10,'b0000000111,2,15); add(10,'b0000000110,3,15); add(10,'b0000000101,0,15);
    add(10,'b0000000100,1,16); add(10,'b0000000011,2,16); add(10,'b0000000010,3,16);
    add(10,'b0000000001,0,16);
  endtask

  // Reference: find the (unique) codeword that prefixes the window.
  function automatic vec_t model(input logic [15:0] b);
    vec_t r;
    r.bits = b; r.tc = 0; r.t1 = 0; r.len = 0; r.err = 1'b1;
    for (int i = 0; i < N_ENT; i++) begin
      if (int'(b >> (16 - e_len[i])) == e_code[i]) begin
        r.tc = e_tc[i]; r.t1 = e_t1[i]; r.len = e_len[i]; r.err = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input vec_t v);
    int n = 0;
    bits = v.bits; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) chk("in_ready_timeout", int'(in_ready), 1);
    else exp_q.push_back(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin step(); n++; end
    chk("drain_left", exp_q.size(), 0);
  endtask

  // Output monitor: compare each transfer against the expected queue and re-encode it.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL spurious_output got=%0h exp=none", pack(int'(tc), int'(t1), int'(len), err));
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", pack(int'(tc), int'(t1), int'(len), err),
            pack(mon_e.tc, mon_e.t1, mon_e.len, mon_e.err));
        if (!mon_e.err) exp_tok = (exp_tok + 1) % 65536;
        if (!err) begin
          enc_ok = 0;
          for (int j = 0; j < N_ENT; j++)
            if (e_t1[j] == int'(t1) && e_tc[j] == int'(tc))
              enc_ok = int'(e_len[j] == int'(len) &&
                            int'(mon_e.bits >> (16 - e_len[j])) == e_code[j]);
          chk("encode_roundtrip", enc_ok, 1);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    build_table();
    vecs[0] = '{bits:16'h3C00, tc:1,  t1:0, len:6,  err:1'b0};
    vecs[1] = '{bits:16'h0040, tc:16, t1:0, len:10, err:1'b0};
    vecs[2] = '{bits:16'h0100, tc:16, t1:1, len:10, err:1'b0};
    vecs[3] = '{bits:16'h0380, tc:13, t1:1, len:9,  err:1'b0};
    vecs[4] = '{bits:16'h0000, tc:0,  t1:0, len:0,  err:1'b1};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_outputs", pack(int'(tc), int'(t1), int'(len), err), 0);
    chk("rst_tok_cnt", int'(tok_cnt), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // First token latency.
    out_ready = 1'b1;
    bits = 16'hF000; in_valid = 1'b1;
    exp_q.push_back('{bits:16'hF000, tc:0, t1:0, len:4, err:1'b0});
    step(); in_valid = 1'b0;
    chk("lat_after_accept", int'(out_valid), 0);
    step();
    chk("lat_after_s1", int'(out_valid), 1);
    step();
    chk("tok_after_first", int'(tok_cnt), 1);

    // Back-to-back directed vectors, then the error vector.
    for (int i = 0; i < 4; i++) send(vecs[i]);
    drain();
    chk("tok_b2b", int'(tok_cnt), exp_tok);
    send(vecs[4]);
    drain();
    chk("tok_err_unchanged", int'(tok_cnt), exp_tok);

    // Consumer stall: two accepted, third blocked, outputs held.
    out_ready = 1'b0;
    bits = 16'h1800; in_valid = 1'b1;
    exp_q.push_back('{bits:16'h1800, tc:10, t1:3, len:7, err:1'b0});
    step();
    bits = 16'hE000;
    exp_q.push_back('{bits:16'hE000, tc:1, t1:1, len:4, err:1'b0});
    step();
    bits = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_hold", pack(int'(tc), int'(t1), int'(len), err) | (int'(out_valid) << 24),
          pack(10, 3, 7, 1'b0) | (1 << 24));
      step();
    end
    exp_q.push_back('{bits:16'h0000, tc:0, t1:0, len:0, err:1'b1});
    out_ready = 1'b1;
    #1 chk("stall_release_ready", int'(in_ready), 1);
    step(); in_valid = 1'b0;
    drain();
    chk("tok_after_stall", int'(tok_cnt), exp_tok);

    // Reset with both stages full.
    out_ready = 1'b0;
    bits = 16'hF000; in_valid = 1'b1; step();
    bits = 16'h2000; step();
    in_valid = 1'b0;
    chk("full_in_ready", int'(in_ready), 0);
    rst_n = 1'b0;
    step();
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_tok_cnt", int'(tok_cnt), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    exp_q.delete();
    exp_tok = 0;
    out_ready = 1'b1;
    repeat (6) step();
    chk("midrst_no_stale", int'(out_valid), 0);

    // Every codeword with random trailing bits.
    for (int i = 0; i < N_ENT; i++) begin
      rnd = 16'($urandom);
      sv.bits = 16'((e_code[i] << (16 - e_len[i])) | (int'(rnd) & ((1 << (16 - e_len[i])) - 1)));
      sv.tc = e_tc[i]; sv.t1 = e_t1[i]; sv.len = e_len[i]; sv.err = 1'b0;
      send(sv);
    end
    drain();
    chk("tok_sweep", int'(tok_cnt), exp_tok);

    // Random windows with random consumer back-pressure and input gaps.
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          rnd = 16'($urandom) >> $urandom_range(0, 11);
          if ($urandom_range(0, 4) == 0) step();
          send(model(rnd));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          step();
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    chk("tok_random", int'(tok_cnt), exp_tok);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
